axi_rd_arb: RTL and testbench

Read-side controller for the cache-to-AXI bridge: arbitrates I-cache line refills and D-cache reads (burst refills or uncached single reads) onto the single AXI AR/R channel pair, one outstanding transaction at a time. Orders reads against the write engine by holding grants while the write buffer is busy and asserting `read_unfinish` while a read is in flight, which blocks new writes.

---
 rtl/axi_rd_arb.sv | 134 +++++++++++++
 tb/tb_axi_rd_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// Read-side AXI controller: arbitrates I-cache refills and D-cache reads onto one
// AR/R channel pair, one outstanding transaction, and interlocks with the write engine.
module axi_rd_arb #(
  parameter int I_BYTES_PER_LINE = 16,
  parameter int D_BYTES_PER_LINE = 16
) (
  input  logic        clk,
  input  logic        resetn,
  // I-cache
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,
  // D-cache
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic        d_rd_burst,
  input  logic [1:0]  d_rd_size,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,
  // write engine interlock
  input  logic        wr_idle,
  output logic        read_unfinish,
  // AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [7:0] I_LEN = 8'(I_BYTES_PER_LINE / 4 - 1);
  localparam logic [7:0] D_LEN = 8'(D_BYTES_PER_LINE / 4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t      state, state_nxt;
  logic        rr, rr_nxt;
  logic        grant_i, grant_d;
  logic        own_d;
  logic [31:0] addr_q;
  logic        burst_q;
  logic [1:0]  size_q;

  logic i_elig, d_elig, d_single, in_r;
  logic unused_r;

  assign i_elig   = i_rd_req & wr_idle;
  assign d_elig   = d_rd_req & wr_idle;
  assign unused_r = ^{rid, rresp};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (d_elig && (!i_elig || !rr)) grant_d = 1'b1;
        else if (i_elig)                grant_i = 1'b1;
        // On contention rr is left pointing at the loser.
        if (i_elig && d_elig) rr_nxt = grant_d;
        if (grant_i || grant_d) state_nxt = S_AR;
      end
      S_AR: if (arready)          state_nxt = S_R;
      S_R:  if (rvalid && rlast)  state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      rr      <= 1'b0;
      own_d   <= 1'b0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      if (grant_i || grant_d) begin
        own_d   <= grant_d;
        addr_q  <= grant_d ? d_rd_addr  : i_rd_addr;
        burst_q <= grant_d ? d_rd_burst : 1'b1;
        size_q  <= grant_d ? d_rd_size  : 2'd2;
      end
    end
  end

  assign i_rd_rdy      = grant_i;
  assign d_rd_rdy      = grant_d;
  assign read_unfinish = (state != S_IDLE);

  // Uncached D reads are a single FIXED beat of 2^size bytes; everything else is a line burst.
  assign d_single = own_d & ~burst_q;
  assign arvalid  = (state == S_AR);
  assign arid     = {3'b000, own_d};
  assign araddr   = addr_q;
  assign arlen    = !own_d ? I_LEN : (burst_q ? D_LEN : 8'd0);
  assign arsize   = d_single ? {1'b0, size_q} : 3'd2;
  assign arburst  = d_single ? 2'b00 : 2'b01;
  assign arlock   = 2'b00;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;

  assign in_r        = (state == S_R);
  assign rready      = in_r;
  assign i_ret_valid = in_r & ~own_d & rvalid;
  assign d_ret_valid = in_r &  own_d & rvalid;
  assign i_ret_last  = in_r & ~own_d & rlast;
  assign d_ret_last  = in_r &  own_d & rlast;
  assign i_ret_data  = rdata;
  assign d_ret_data  = rdata;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb: directed steps plus randomized AXI timing,
// checked against expectations derived from the request and arbitration rules.
module tb_axi_rd_arb;

  localparam int I_BPL = 16;
  localparam int D_BPL = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_rd_req, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [31:0] i_rd_addr, i_ret_data;
  logic        d_rd_req, d_rd_burst, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [1:0]  d_rd_size;
  logic [31:0] d_rd_addr, d_ret_data;
  logic        wr_idle, read_unfinish;
  logic [3:0]  arid, arcache, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  bit last_win_d;   // model: on a contested request, whoever did not win last contest wins

  axi_rd_arb #(.I_BYTES_PER_LINE(I_BPL), .D_BYTES_PER_LINE(D_BPL)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_burst(d_rd_burst), .d_rd_size(d_rd_size),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .wr_idle(wr_idle), .read_unfinish(read_unfinish),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // First cycle after a transaction: release the R channel inputs.
  task automatic cyc_idle();
    cyc();
    rvalid  = 1'b0;
    rlast   = 1'b0;
    arready = 1'b0;
  endtask

  // Let combinational outputs settle, then check the IDLE-cycle grant outcome.
  task automatic expect_grant(input bit ei, input bit ed);
    #1;
    chk("i_rd_rdy", 32'(i_rd_rdy), 32'(ei));
    chk("d_rd_rdy", 32'(d_rd_rdy), 32'(ed));
    chk("idle_unfinish", 32'(read_unfinish), 32'd0);
    chk("idle_arvalid", 32'(arvalid), 32'd0);
    chk("idle_rready", 32'(rready), 32'd0);
    chk("idle_ret_valid", 32'({i_ret_valid, d_ret_valid}), 32'd0);
  endtask

  // Model winner of a request set, per the round-robin rule.
  function automatic bit pick_d(input bit ri, input bit rd);
    bit wd;
    if (ri && rd) begin
      wd = !last_win_d;
      last_win_d = wd;
    end else wd = rd;
    return wd;
  endfunction

  // Drive one transaction from the AR cycle to its last R beat, acting as the AXI slave.
  task automatic run_txn(input bit own_d, input logic [31:0] addr, input bit burst,
                         input logic [1:0] size, input int ar_wait, input bit gaps,
                         input bit rand_data, input logic [31:0] base, input int abort_after);
    logic [7:0]  e_len;
    logic [2:0]  e_size;
    logic [1:0]  e_burst;
    logic [31:0] d;
    int beats, b, budget;
    if (!own_d)     begin e_len = 8'(I_BPL / 4 - 1); e_size = 3'd2; e_burst = 2'b01; end
    else if (burst) begin e_len = 8'(D_BPL / 4 - 1); e_size = 3'd2; e_burst = 2'b01; end
    else            begin e_len = 8'd0; e_size = {1'b0, size};      e_burst = 2'b00; end
    beats = int'(e_len) + 1;

    for (int w = 0; w <= ar_wait; w++) begin
      cyc();
      if (w == 0) begin
        if (own_d) d_rd_req = 1'b0;
        else       i_rd_req = 1'b0;
      end
      arready = (w == ar_wait);
      #1;
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("araddr", araddr, addr);
      chk("arid", 32'(arid), 32'(own_d));
      chk("arlen", 32'(arlen), 32'(e_len));
      chk("arsize", 32'(arsize), 32'(e_size));
      chk("arburst", 32'(arburst), 32'(e_burst));
      chk("ar_unfinish", 32'(read_unfinish), 32'd1);
      chk("busy_rdy", 32'({i_rd_rdy, d_rd_rdy}), 32'd0);
      if (w == 0) chk("ar_misc", 32'({arlock, arcache, arprot}), 32'd0);
    end

    b = 0;
    budget = 0;
    while (b < beats && budget < 200) begin
      cyc();
      arready = 1'b0;
      rvalid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d       = rand_data ? $urandom : base + 32'(b);
      rdata   = d;
      rlast   = rvalid && (b == beats - 1);
      #1;
      chk("rready", 32'(rready), 32'd1);
      chk("r_arvalid", 32'(arvalid), 32'd0);
      chk("r_unfinish", 32'(read_unfinish), 32'd1);
      chk("own_ret_valid", 32'(own_d ? d_ret_valid : i_ret_valid), 32'(rvalid));
      chk("other_ret_valid", 32'(own_d ? i_ret_valid : d_ret_valid), 32'd0);
      if (rvalid) begin
        chk("ret_data", own_d ? d_ret_data : i_ret_data, d);
        chk("ret_last", 32'(own_d ? d_ret_last : i_ret_last), 32'(b == beats - 1));
        b++;
      end
      budget++;
      if (abort_after > 0 && b == abort_after) break;
    end

    if (abort_after > 0) begin
      cyc();
      rvalid = 1'b0;
      rlast  = 1'b0;
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      #1;
      chk("abort_rready", 32'(rready), 32'd0);
      chk("abort_unfinish", 32'(read_unfinish), 32'd0);
      chk("abort_arvalid", 32'(arvalid), 32'd0);
      last_win_d = 1'b0;
    end else begin
      chk("beats_done", 32'(b), 32'(beats));
    end
  endtask

  initial begin
    bit          wd, rb;
    logic [31:0] ia, da;
    logic [1:0]  rs;

    resetn = 1'b0; wr_idle = 1'b1;
    i_rd_req = 1'b0; i_rd_addr = '0;
    d_rd_req = 1'b0; d_rd_addr = '0; d_rd_burst = 1'b0; d_rd_size = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
    last_win_d = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_unfinish", 32'(read_unfinish), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_rdy", 32'({i_rd_rdy, d_rd_rdy}), 32'd0);
    chk("rst_ret_valid", 32'({i_ret_valid, d_ret_valid}), 32'd0);
    resetn = 1'b1;

    // I-cache refill alone, beats A0..A3
    cyc();
    i_rd_req = 1'b1; i_rd_addr = 32'h1fc0_0000;
    expect_grant(1'b1, 1'b0);
    run_txn(1'b0, 32'h1fc0_0000, 1'b1, 2'd2, 0, 1'b0, 1'b0, 32'hA0, 0);

    // D uncached halfword read
    cyc_idle();
    d_rd_req = 1'b1; d_rd_addr = 32'hbfaf_8002; d_rd_burst = 1'b0; d_rd_size = 2'd1;
    expect_grant(1'b0, 1'b1);
    run_txn(1'b1, 32'hbfaf_8002, 1'b0, 2'd1, 0, 1'b0, 1'b1, 32'h0, 0);

    // Both held for three rounds: D, I, D
    cyc_idle();
    for (int r = 0; r < 3; r++) begin
      ia = $urandom & 32'hffff_fff0;
      da = $urandom & 32'hffff_fff0;
      i_rd_req = 1'b1; i_rd_addr = ia;
      d_rd_req = 1'b1; d_rd_addr = da; d_rd_burst = 1'b1; d_rd_size = 2'd2;
      wd = pick_d(1'b1, 1'b1);
      chk("rr_order", 32'(wd), 32'(r != 1));
      expect_grant(!wd, wd);
      run_txn(wd, wd ? da : ia, 1'b1, 2'd2, 0, 1'b0, 1'b1, 32'h0, 0);
      cyc_idle();
    end
    i_rd_req = 1'b0;
    expect_grant(1'b0, 1'b0);

    // Write engine busy blocks the grant
    cyc();
    wr_idle = 1'b0;
    da = $urandom & 32'hffff_fff0;
    d_rd_req = 1'b1; d_rd_addr = da; d_rd_burst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) cyc();
      #1;
      chk("blocked_rdy", 32'(d_rd_rdy), 32'd0);
      chk("blocked_arvalid", 32'(arvalid), 32'd0);
    end
    cyc();
    wr_idle = 1'b1;
    expect_grant(1'b0, 1'b1);
    run_txn(1'b1, da, 1'b1, 2'd2, 0, 1'b0, 1'b1, 32'h0, 0);

    // Randomized single-requester traffic with AR stalls and R gaps
    for (int t = 0; t < 10; t++) begin
      cyc_idle();
      wd = 1'($urandom);
      rb = 1'($urandom);
      rs = 2'($urandom_range(0, 2));
      ia = $urandom & 32'hffff_fff0;
      da = $urandom;
      if (wd) begin
        d_rd_req = 1'b1; d_rd_addr = da; d_rd_burst = rb; d_rd_size = rs;
      end else begin
        i_rd_req = 1'b1; i_rd_addr = ia;
      end
      expect_grant(!wd, wd);
      run_txn(wd, wd ? da : ia, rb, rs, (t == 0) ? 3 : int'($urandom_range(0, 3)),
              1'b1, 1'b1, 32'h0, 0);
    end

    // Reset in the middle of a burst, then normal operation resumes
    cyc_idle();
    ia = $urandom & 32'hffff_fff0;
    i_rd_req = 1'b1; i_rd_addr = ia;
    expect_grant(1'b1, 1'b0);
    run_txn(1'b0, ia, 1'b1, 2'd2, 0, 1'b0, 1'b1, 32'h0, 2);

    cyc();
    ia = $urandom & 32'hffff_fff0;
    da = $urandom & 32'hffff_fff0;
    i_rd_req = 1'b1; i_rd_addr = ia;
    d_rd_req = 1'b1; d_rd_addr = da; d_rd_burst = 1'b1;
    wd = pick_d(1'b1, 1'b1);
    expect_grant(!wd, wd);
    run_txn(wd, wd ? da : ia, 1'b1, 2'd2, 1, 1'b1, 1'b1, 32'h0, 0);
    cyc_idle();
    wd = pick_d(i_rd_req, d_rd_req);
    expect_grant(!wd, wd);
    run_txn(wd, wd ? da : ia, 1'b1, 2'd2, 0, 1'b1, 1'b1, 32'h0, 0);
    cyc_idle();
    expect_grant(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
